// File: rtl/udma_filter_rx_datastore.sv
// Filter RX data store: forwards the filter output stream to a uDMA RX channel as L2 writes,
// generating linear, circular or 2D addresses and flagging SOF/EOF framing mismatches.
module udma_filter_rx_datastore #(
   parameter int DATA_WIDTH     = 32,
   parameter int L2_AWIDTH_NOAL = 15,
   parameter int TRANS_SIZE     = 16
) (
   input  logic                      clk_i,
   input  logic                      resetn_i,

   output logic                      rx_ch_valid_o,
   output logic [L2_AWIDTH_NOAL-1:0] rx_ch_addr_o,
   output logic [1:0]                rx_ch_datasize_o,
   output logic [DATA_WIDTH-1:0]     rx_ch_data_o,
   input  logic                      rx_ch_ready_i,

   input  logic                      cmd_start_i,
   output logic                      cmd_done_o,
   output logic                      status_busy_o,
   output logic                      status_err_o,

   input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
   input  logic [1:0]                cfg_datasize_i,
   input  logic [1:0]                cfg_mode_i,
   input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
   input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
   input  logic [TRANS_SIZE-1:0]     cfg_len2_i,

   input  logic [DATA_WIDTH-1:0]     stream_data_i,
   input  logic [1:0]                stream_datasize_i,
   input  logic                      stream_valid_i,
   input  logic                      stream_sof_i,
   input  logic                      stream_eof_i,
   output logic                      stream_ready_o
);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_RUNNING = 1'b1
   } state_t;

   localparam logic [1:0] MODE_LINEAR = 2'd0;
   localparam logic [1:0] MODE_2D     = 2'd3;

   state_t                    r_state;
   logic [1:0]                r_mode;
   logic [L2_AWIDTH_NOAL-1:0] r_row_start;
   logic [L2_AWIDTH_NOAL-1:0] r_ptr;
   logic [TRANS_SIZE-1:0]     r_w;
   logic [TRANS_SIZE-1:0]     r_l;
   logic                      r_err;

   logic                      w_running;
   logic                      w_beat;
   logic                      w_row_end;
   logic                      w_last;
   logic                      w_frame_bad;
   logic [L2_AWIDTH_NOAL-1:0] w_inc;
   logic [L2_AWIDTH_NOAL-1:0] w_stride;
   logic [L2_AWIDTH_NOAL-1:0] w_next_row;
   logic                      w_unused;

   assign w_unused = ^{stream_datasize_i, cfg_len2_i};

   assign w_running = (r_state == ST_RUNNING);
   assign w_beat    = stream_valid_i & rx_ch_ready_i & w_running;
   assign w_row_end = (r_w == cfg_len0_i);
   // Modes 0 and 1 are both linear: only the final row end terminates, and len1 is ignored.
   assign w_last    = w_row_end & (~r_mode[1] | (r_l == cfg_len1_i));

   // A frame starts on the first beat of each row and ends on each row's last beat.
   assign w_frame_bad = (stream_sof_i != (r_w == '0)) | (stream_eof_i != w_row_end);

   always_comb begin
      w_inc = '0;
      case (cfg_datasize_i)
         2'd0:    w_inc = L2_AWIDTH_NOAL'(1);
         2'd1:    w_inc = L2_AWIDTH_NOAL'(2);
         2'd2:    w_inc = L2_AWIDTH_NOAL'(4);
         default: w_inc = '0;
      endcase
   end

   assign w_stride   = L2_AWIDTH_NOAL'(cfg_len2_i);
   assign w_next_row = r_row_start + w_stride;

   assign rx_ch_valid_o    = stream_valid_i & w_running;
   assign stream_ready_o   = rx_ch_ready_i & w_running;
   assign rx_ch_data_o     = w_running ? stream_data_i : '0;
   assign rx_ch_datasize_o = w_running ? cfg_datasize_i : 2'b00;
   assign rx_ch_addr_o     = r_ptr;
   assign cmd_done_o       = w_beat & w_last;
   assign status_busy_o    = w_running;
   assign status_err_o     = r_err;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_state     <= ST_IDLE;
         r_mode      <= MODE_LINEAR;
         r_row_start <= '0;
         r_ptr       <= '0;
         r_w         <= '0;
         r_l         <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_start_i) begin
                  r_state     <= ST_RUNNING;
                  r_mode      <= cfg_mode_i;
                  r_row_start <= cfg_start_addr_i;
                  r_ptr       <= cfg_start_addr_i;
                  r_w         <= '0;
                  r_l         <= '0;
                  r_err       <= 1'b0;
               end
            end
            ST_RUNNING: begin
               if (w_beat) begin
                  if (w_frame_bad) begin
                     r_err <= 1'b1;
                  end
                  if (w_last) begin
                     r_state <= ST_IDLE;
                  end else if (w_row_end) begin
                     r_w <= '0;
                     r_l <= r_l + TRANS_SIZE'(1);
                     if (r_mode == MODE_2D) begin
                        r_row_start <= w_next_row;
                        r_ptr       <= w_next_row;
                     end else begin
                        r_ptr <= r_row_start;
                     end
                  end else begin
                     r_w   <= r_w + TRANS_SIZE'(1);
                     r_ptr <= r_ptr + w_inc;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udma_filter_rx_datastore.sv
// Testbench for udma_filter_rx_datastore: table-driven transfers, a reset-abort sequence and
// randomized transfers, each checked beat by beat against a nested-loop address model.
module tb_udma_filter_rx_datastore;

   logic        clk_i = 1'b0;
   logic        resetn_i;
   logic        rx_ch_valid_o;
   logic [14:0] rx_ch_addr_o;
   logic [1:0]  rx_ch_datasize_o;
   logic [31:0] rx_ch_data_o;
   logic        rx_ch_ready_i;
   logic        cmd_start_i;
   logic        cmd_done_o;
   logic        status_busy_o;
   logic        status_err_o;
   logic [14:0] cfg_start_addr_i;
   logic [1:0]  cfg_datasize_i;
   logic [1:0]  cfg_mode_i;
   logic [15:0] cfg_len0_i;
   logic [15:0] cfg_len1_i;
   logic [15:0] cfg_len2_i;
   logic [31:0] stream_data_i;
   logic [1:0]  stream_datasize_i;
   logic        stream_valid_i;
   logic        stream_sof_i;
   logic        stream_eof_i;
   logic        stream_ready_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   udma_filter_rx_datastore dut (
      .clk_i             (clk_i),
      .resetn_i          (resetn_i),
      .rx_ch_valid_o     (rx_ch_valid_o),
      .rx_ch_addr_o      (rx_ch_addr_o),
      .rx_ch_datasize_o  (rx_ch_datasize_o),
      .rx_ch_data_o      (rx_ch_data_o),
      .rx_ch_ready_i     (rx_ch_ready_i),
      .cmd_start_i       (cmd_start_i),
      .cmd_done_o        (cmd_done_o),
      .status_busy_o     (status_busy_o),
      .status_err_o      (status_err_o),
      .cfg_start_addr_i  (cfg_start_addr_i),
      .cfg_datasize_i    (cfg_datasize_i),
      .cfg_mode_i        (cfg_mode_i),
      .cfg_len0_i        (cfg_len0_i),
      .cfg_len1_i        (cfg_len1_i),
      .cfg_len2_i        (cfg_len2_i),
      .stream_data_i     (stream_data_i),
      .stream_datasize_i (stream_datasize_i),
      .stream_valid_i    (stream_valid_i),
      .stream_sof_i      (stream_sof_i),
      .stream_eof_i      (stream_eof_i),
      .stream_ready_o    (stream_ready_o)
   );

   typedef struct {
      logic [1:0]  mode;
      logic [14:0] addr;
      logic [1:0]  size;
      logic [15:0] len0;
      logic [15:0] len1;
      logic [15:0] len2;
      int          rdy_mode;   // 0 always ready, 1 toggle, 2 random valid/ready
      int          bad_beat;   // beat whose eof is inverted, -1 none
      bit          ghost;      // pulse cmd_start_i mid-transfer
      int          exp_n;
      logic [14:0] exp_last;
      bit          exp_err;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: write addresses and frame flags listed row by row from the transfer description.
   task automatic run_xfer(input vec_t v, output int nbeats, output logic [14:0] last_addr,
                           output logic got_err);
      logic [14:0] q_addr[$];
      bit          q_sof[$];
      bit          q_eof[$];
      int          inc, rows, n, idx, cyc, base;
      bit          first, vld, rdy;
      inc  = (v.size == 2'd3) ? 0 : (1 << v.size);
      rows = (v.mode < 2'd2) ? 1 : int'(v.len1) + 1;
      for (int r = 0; r < rows; r++) begin
         base = (v.mode == 2'd3) ? int'(v.addr) + r * int'(v.len2) : int'(v.addr);
         for (int c = 0; c <= int'(v.len0); c++) begin
            q_addr.push_back(15'((base + c * inc) & 32'h7fff));
            q_sof.push_back(c == 0);
            q_eof.push_back(c == int'(v.len0));
         end
      end
      n = q_addr.size();
      last_addr = 'x;

      cfg_mode_i = v.mode; cfg_start_addr_i = v.addr; cfg_datasize_i = v.size;
      cfg_len0_i = v.len0; cfg_len1_i = v.len1; cfg_len2_i = v.len2;
      cmd_start_i = 1'b1; stream_valid_i = 1'b1; rx_ch_ready_i = 1'b1;
      @(negedge clk_i);
      chk("idle_ready", stream_ready_o, 1'b0);
      chk("idle_valid", rx_ch_valid_o, 1'b0);
      @(posedge clk_i); #1;
      cmd_start_i = 1'b0;

      idx = 0; cyc = 0; first = 1'b1;
      while (idx < n && cyc < 2000) begin
         vld = (v.rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         rdy = (v.rdy_mode == 2) ? 1'($urandom_range(0, 1)) :
               (v.rdy_mode == 1) ? ((cyc % 2) == 0) : 1'b1;
         stream_valid_i = vld; rx_ch_ready_i = rdy; stream_data_i = $urandom;
         stream_sof_i = q_sof[idx];
         stream_eof_i = q_eof[idx] ^ (idx == v.bad_beat);
         cmd_start_i = v.ghost && (idx == 1);
         cfg_start_addr_i = (v.ghost && idx == 1) ? ~v.addr : v.addr;
         @(negedge clk_i);
         if (first) chk("err_clear_on_start", status_err_o, 1'b0);
         first = 1'b0;
         chk("busy", status_busy_o, 1'b1);
         chk("ready_mirror", stream_ready_o, rdy);
         chk("valid_pass", rx_ch_valid_o, vld);
         chk("addr", rx_ch_addr_o, q_addr[idx]);
         chk("datasize", rx_ch_datasize_o, v.size);
         chk("data_pass", rx_ch_data_o, stream_data_i);
         chk("done", cmd_done_o, (vld && rdy && idx == n - 1));
         if (vld && rdy) begin
            last_addr = q_addr[idx];
            idx++;
         end
         cyc++;
         @(posedge clk_i); #1;
      end
      if (idx < n) chk("beat_timeout", idx, n);
      stream_valid_i = 1'b0; cmd_start_i = 1'b0; cfg_start_addr_i = v.addr;
      @(negedge clk_i);
      chk("idle_after_done", status_busy_o, 1'b0);
      chk("no_extra_done", cmd_done_o, 1'b0);
      got_err = status_err_o;
      nbeats  = idx;
      @(posedge clk_i); #1;
   endtask

   initial begin
      int          nb;
      logic [14:0] la;
      logic        ge;
      vec_t        rv;

      vecs[0] = '{2'd0, 15'h100,  2'd2, 16'd3, 16'd0, 16'h0,   0, -1, 1'b0, 4, 15'h10C, 1'b0};
      vecs[1] = '{2'd3, 15'h000,  2'd0, 16'd1, 16'd2, 16'h10,  0, -1, 1'b0, 6, 15'h021, 1'b0};
      vecs[2] = '{2'd2, 15'h040,  2'd1, 16'd1, 16'd1, 16'h0,   0, -1, 1'b0, 4, 15'h042, 1'b0};
      vecs[3] = '{2'd0, 15'h300,  2'd2, 16'd7, 16'd0, 16'h0,   1, -1, 1'b0, 8, 15'h31C, 1'b0};
      vecs[4] = '{2'd3, 15'h000,  2'd0, 16'd1, 16'd2, 16'h10,  0,  1, 1'b0, 6, 15'h021, 1'b1};
      vecs[5] = '{2'd1, 15'h7FFE, 2'd1, 16'd2, 16'd5, 16'h0,   0, -1, 1'b0, 3, 15'h002, 1'b0};
      vecs[6] = '{2'd2, 15'h010,  2'd2, 16'd0, 16'd3, 16'h0,   0, -1, 1'b0, 4, 15'h010, 1'b0};
      vecs[7] = '{2'd0, 15'h055,  2'd3, 16'd2, 16'd0, 16'h0,   0, -1, 1'b0, 3, 15'h055, 1'b0};
      vecs[8] = '{2'd3, 15'h080,  2'd2, 16'd2, 16'd1, 16'h100, 2, -1, 1'b1, 6, 15'h188, 1'b0};
      vecs[9] = '{2'd0, 15'h200,  2'd2, 16'd1, 16'd0, 16'h0,   0, -1, 1'b0, 2, 15'h204, 1'b0};

      resetn_i = 1'b0; cmd_start_i = 1'b0; rx_ch_ready_i = 1'b0; stream_valid_i = 1'b0;
      stream_sof_i = 1'b0; stream_eof_i = 1'b0; stream_data_i = '0; stream_datasize_i = 2'd2;
      cfg_start_addr_i = '0; cfg_datasize_i = '0; cfg_mode_i = '0;
      cfg_len0_i = '0; cfg_len1_i = '0; cfg_len2_i = '0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_valid", rx_ch_valid_o, 1'b0);
      chk("rst_ready", stream_ready_o, 1'b0);
      chk("rst_done", cmd_done_o, 1'b0);
      chk("rst_busy", status_busy_o, 1'b0);
      chk("rst_err", status_err_o, 1'b0);
      chk("rst_addr", rx_ch_addr_o, 15'h0);
      resetn_i = 1'b1;
      @(posedge clk_i); #1;

      for (int i = 0; i < 9; i++) begin
         run_xfer(vecs[i], nb, la, ge);
         $display("[TB] vec %0d mode=%0d addr=0x%0h beats=%0d last=0x%0h err=%0d",
                  i, vecs[i].mode, vecs[i].addr, nb, la, ge);
         chk("vec_beats", nb, vecs[i].exp_n);
         chk("vec_last_addr", la, vecs[i].exp_last);
         chk("vec_err", ge, vecs[i].exp_err);
      end

      // Reset after two of four linear beats: everything drops at once and no done pulse appears.
      cfg_mode_i = 2'd0; cfg_start_addr_i = 15'h100; cfg_datasize_i = 2'd2; cfg_len0_i = 16'd3;
      cmd_start_i = 1'b1; stream_valid_i = 1'b1; rx_ch_ready_i = 1'b1;
      stream_sof_i = 1'b1; stream_eof_i = 1'b0;
      @(posedge clk_i); #1;
      cmd_start_i = 1'b0;
      @(negedge clk_i);
      chk("abort_beat0_addr", rx_ch_addr_o, 15'h100);
      chk("abort_beat0_done", cmd_done_o, 1'b0);
      @(posedge clk_i); #1;
      stream_sof_i = 1'b0;
      @(negedge clk_i);
      chk("abort_beat1_addr", rx_ch_addr_o, 15'h104);
      chk("abort_beat1_done", cmd_done_o, 1'b0);
      @(posedge clk_i); #1;
      resetn_i = 1'b0;
      #1;
      chk("abort_valid", rx_ch_valid_o, 1'b0);
      chk("abort_ready", stream_ready_o, 1'b0);
      chk("abort_done", cmd_done_o, 1'b0);
      chk("abort_busy", status_busy_o, 1'b0);
      chk("abort_addr", rx_ch_addr_o, 15'h0);
      @(negedge clk_i);
      resetn_i = 1'b1; stream_valid_i = 1'b0;
      @(posedge clk_i); #1;
      $display("[TB] reset abort after 2 beats, restarting at 0x200");
      run_xfer(vecs[9], nb, la, ge);
      $display("[TB] restart beats=%0d last=0x%0h err=%0d", nb, la, ge);
      chk("restart_beats", nb, vecs[9].exp_n);
      chk("restart_last", la, vecs[9].exp_last);

      for (int i = 0; i < 20; i++) begin
         rv.mode = 2'($urandom_range(0, 3));
         rv.addr = 15'($urandom);
         rv.size = 2'($urandom_range(0, 3));
         rv.len0 = 16'($urandom_range(0, 7));
         rv.len1 = 16'($urandom_range(0, 3));
         rv.len2 = 16'($urandom);
         rv.rdy_mode = 2; rv.bad_beat = -1; rv.ghost = 1'($urandom_range(0, 1));
         rv.exp_n = 0; rv.exp_last = '0; rv.exp_err = 1'b0;
         run_xfer(rv, nb, la, ge);
         $display("[TB] rand %0d mode=%0d addr=0x%0h size=%0d len0=%0d len1=%0d len2=0x%0h beats=%0d err=%0d",
                  i, rv.mode, rv.addr, rv.size, rv.len0, rv.len1, rv.len2, nb, ge);
         chk("rand_err", ge, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
